deparser_shift_replace_stream: RTL and testbench

Parametrised deparser stage that strips a leading byte offset from each packet head stream and rewrites per-packet metadata. Generalises fixed-width tag-driven shift/replace to a valid/ready streaming interface with configurable slice width, shift granularity, slot/field counts and multi-slot metadata shift. Sits between the field-extract stage and the deparser output FIFO.

---
 rtl/deparser_shift_replace_stream.sv | 168 ++++++++++++++++
 tb/tb_deparser_shift_replace_stream.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deparser_shift_replace_stream.sv
// Deparser stage: drops a leading unit offset from each head stream and rewrites packet meta.
// Optional build macro SRH_STATS_EN adds packet and replaced-slot counters.
module deparser_shift_replace_stream #(
  parameter int HEAD_W     = 512,
  parameter int SHIFT_W    = 8,
  parameter int FIELD_W    = 32,
  parameter int KEY_NUM    = 8,
  parameter int META_SLOTS = 8,
  parameter int META_W     = META_SLOTS * FIELD_W,
  parameter int SHW        = $clog2(HEAD_W / SHIFT_W),
  parameter int KIW        = $clog2(KEY_NUM),
  parameter int MSW        = $clog2(META_SLOTS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_head_valid,
  output logic                        o_head_ready,
  input  logic [HEAD_W-1:0]           i_head_data,
  input  logic                        i_head_start,
  input  logic                        i_head_last,
  input  logic [SHW-1:0]              i_head_shift,
  input  logic [META_W-1:0]           i_meta,
  input  logic [MSW-1:0]              i_meta_shift,
  input  logic [KEY_NUM*FIELD_W-1:0]  i_ext_field,
  input  logic [META_SLOTS*(KIW+1)-1:0] i_replace,
  output logic                        o_head_valid,
  input  logic                        i_head_ready,
  output logic [HEAD_W-1:0]           o_head_data,
  output logic                        o_head_start,
  output logic                        o_head_last,
  output logic [META_W-1:0]           o_meta,
  output logic                        o_err,
  output logic [1:0]                  o_dbg_state
`ifdef SRH_STATS_EN
  ,
  output logic [31:0]                 o_pkt_cnt,
  output logic [31:0]                 o_rep_cnt
`endif
);

  // Handshake: a beat moves when valid&ready are both high on a rising edge; valid never
  // waits for ready, and the output register holds its contents while valid&~ready.
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;

  state_t             state;
  logic [HEAD_W-1:0]  hold;
  logic [SHW-1:0]     shift_q;
  logic               first_q;
  logic               out_free;
  logic               accept;
  logic               start_in_stream;
  logic [META_W-1:0]  meta_rep;
  logic [META_W-1:0]  meta_new;
  logic [KIW:0]       ent;
  logic [KIW-1:0]     idx;
  logic [MSW-1:0]     rep_num;

  assign out_free        = ~o_head_valid | i_head_ready;
  assign start_in_stream = (state == STREAM) & i_head_valid & i_head_start;
  assign o_head_ready    = (state != FLUSH) & out_free & ~start_in_stream;
  assign accept          = i_head_valid & o_head_ready;
  assign o_dbg_state     = state;

  // Upper HEAD_W bits of {a,b} after discarding s leading units.
  function automatic logic [HEAD_W-1:0] window(input logic [HEAD_W-1:0] a,
                                                input logic [HEAD_W-1:0] b,
                                                input logic [SHW-1:0]    s);
    logic [2*HEAD_W-1:0] w;
    w = {a, b} << (int'(s) * SHIFT_W);
    return w[2*HEAD_W-1 -: HEAD_W];
  endfunction

  // Slot 0, field 0 and replace entry 0 all sit at the MSBs of their buses.
  always_comb begin
    meta_rep = i_meta;
    rep_num  = '0;
    ent      = '0;
    idx      = '0;
    for (int i = 0; i < META_SLOTS; i++) begin
      ent = i_replace[(META_SLOTS-1-i)*(KIW+1) +: KIW+1];
      idx = ent[KIW-1:0];
      if (ent[KIW] && (int'(idx) < KEY_NUM)) begin
        meta_rep[(META_SLOTS-1-i)*FIELD_W +: FIELD_W] =
          i_ext_field[(KEY_NUM-1-int'(idx))*FIELD_W +: FIELD_W];
        rep_num = rep_num + MSW'(1);
      end
    end
    if (int'(i_meta_shift) >= META_SLOTS) meta_new = '0;
    else meta_new = meta_rep << (int'(i_meta_shift) * FIELD_W);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      hold         <= '0;
      shift_q      <= '0;
      first_q      <= 1'b0;
      o_head_valid <= 1'b0;
      o_head_data  <= '0;
      o_head_start <= 1'b0;
      o_head_last  <= 1'b0;
      o_meta       <= '0;
      o_err        <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (o_head_valid && i_head_ready) o_head_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && i_head_start) begin
            shift_q <= i_head_shift;
            o_meta  <= meta_new;
            if (i_head_last) begin
              // A one-slice packet goes straight out; there is nothing to merge with.
              o_head_data  <= window(i_head_data, '0, i_head_shift);
              o_head_start <= 1'b1;
              o_head_last  <= 1'b1;
              o_head_valid <= 1'b1;
            end else begin
              hold    <= i_head_data;
              first_q <= 1'b1;
              state   <= STREAM;
            end
          end else if (accept) begin
            o_err <= 1'b1;
          end
        end
        STREAM: begin
          if (start_in_stream) begin
            o_err <= 1'b1;
            state <= FLUSH;
          end else if (accept) begin
            o_head_data  <= window(hold, i_head_data, shift_q);
            o_head_start <= first_q;
            o_head_last  <= 1'b0;
            o_head_valid <= 1'b1;
            first_q      <= 1'b0;
            hold         <= i_head_data;
            if (i_head_last) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (out_free) begin
            o_head_data  <= window(hold, '0, shift_q);
            o_head_start <= first_q;
            o_head_last  <= 1'b1;
            o_head_valid <= 1'b1;
            first_q      <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRH_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_cnt <= '0;
      o_rep_cnt <= '0;
    end else begin
      if (o_head_valid && i_head_ready && o_head_last) o_pkt_cnt <= o_pkt_cnt + 32'd1;
      if (accept && i_head_start && (state == IDLE)) o_rep_cnt <= o_rep_cnt + 32'(rep_num);
    end
  end
`endif

endmodule

// File: tb/tb_deparser_shift_replace_stream.sv
// Directed bench for deparser_shift_replace_stream: byte-stream expectations, meta table, corner sequences.
module tb_deparser_shift_replace_stream;
  localparam int HW  = 512;
  localparam int KN  = 6;
  localparam int MW  = 256;
  localparam int SHW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_head_valid;
  logic              o_head_ready;
  logic [HW-1:0]     i_head_data;
  logic              i_head_start;
  logic              i_head_last;
  logic [SHW-1:0]    i_head_shift;
  logic [MW-1:0]     i_meta;
  logic [3:0]        i_meta_shift;
  logic [KN*32-1:0]  i_ext_field;
  logic [31:0]       i_replace;
  logic              o_head_valid;
  logic              i_head_ready;
  logic [HW-1:0]     o_head_data;
  logic              o_head_start;
  logic              o_head_last;
  logic [MW-1:0]     o_meta;
  logic              o_err;
  logic [1:0]        o_dbg_state;
`ifdef SRH_STATS_EN
  logic [31:0]       pkt_cnt;
  logic [31:0]       rep_cnt;
`endif

  deparser_shift_replace_stream #(.KEY_NUM(KN)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_head_valid(i_head_valid), .o_head_ready(o_head_ready),
    .i_head_data(i_head_data), .i_head_start(i_head_start), .i_head_last(i_head_last),
    .i_head_shift(i_head_shift), .i_meta(i_meta), .i_meta_shift(i_meta_shift),
    .i_ext_field(i_ext_field), .i_replace(i_replace),
    .o_head_valid(o_head_valid), .i_head_ready(i_head_ready),
    .o_head_data(o_head_data), .o_head_start(o_head_start), .o_head_last(o_head_last),
    .o_meta(o_meta), .o_err(o_err), .o_dbg_state(o_dbg_state)
`ifdef SRH_STATS_EN
    , .o_pkt_cnt(pkt_cnt), .o_rep_cnt(rep_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            errors = 0;
  int            checks = 0;
  int            err_seen = 0;
  logic [HW+1:0] exp_q[$];
  logic [HW+1:0] exp_e;
  logic          bp_mode = 1'b0;
  logic          stall_prev = 1'b0;
  logic [HW-1:0] stall_data;

  typedef struct {
    logic [3:0]  rep[8];
    logic [3:0]  ms;
    logic [31:0] exp[8];
  } meta_vec_t;
  meta_vec_t   tbl[9];
  logic [31:0] orig[8];

  task automatic chk(input string name, input logic [HW+1:0] act, input logic [HW+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] pack_meta(input logic [31:0] s[8]);
    logic [MW-1:0] r;
    for (int i = 0; i < 8; i++) r[(7-i)*32 +: 32] = s[i];
    return r;
  endfunction

  function automatic logic [31:0] pack_rep(input logic [3:0] e[8]);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[(7-i)*4 +: 4] = e[i];
    return r;
  endfunction

  function automatic logic [HW-1:0] in_slice(input int k, input logic [7:0] base);
    logic [HW-1:0] r;
    for (int j = 0; j < 64; j++) r[HW-1-8*j -: 8] = 8'(int'(base) + k*64 + j);
    return r;
  endfunction

  // Output byte j of the packet is input byte j+s, or zero past the end.
  function automatic logic [HW-1:0] exp_slice(input int n, input int s, input int k,
                                              input logic [7:0] base);
    logic [HW-1:0] r;
    for (int j = 0; j < 64; j++) begin
      int p;
      p = k*64 + j + s;
      r[HW-1-8*j -: 8] = (p < n*64) ? 8'(int'(base) + p) : 8'h00;
    end
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) chk("stall_hold", {2'b01, o_head_data} | {1'b0, o_head_valid, {HW{1'b0}}},
                          {2'b01, stall_data});
      if (o_head_valid && i_head_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got start=%0b last=%0b data=%0h expected none",
                   o_head_start, o_head_last, o_head_data);
        end else begin
          exp_e = exp_q.pop_front();
          chk("out_slice", {o_head_start, o_head_last, o_head_data}, exp_e);
        end
      end
      if (o_dbg_state == 2'd2) chk("flush_ready", {{HW+1{1'b0}}, o_head_ready}, '0);
      if (o_err) err_seen++;
      stall_prev = o_head_valid && !i_head_ready;
      stall_data = o_head_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Downstream ready: constant 1, or toggling 1,0,1,0 in backpressure mode.
  always @(posedge clk) begin
    #1;
    if (bp_mode) i_head_ready = ~i_head_ready;
    else i_head_ready = 1'b1;
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [HW-1:0] d, input logic st, input logic ls,
                           input logic [SHW-1:0] sh);
    int   n;
    logic rdy;
    i_head_valid = 1'b1;
    i_head_data  = d;
    i_head_start = st;
    i_head_last  = ls;
    i_head_shift = sh;
    n = 0;
    do begin
      @(negedge clk);
      rdy = o_head_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 for %0d cycles expected acceptance", n);
    end
    i_head_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input int s, input logic [7:0] base, input logic close_last);
    for (int k = 0; k < n; k++) exp_q.push_back({k == 0, k == n-1, exp_slice(n, s, k, base)});
    for (int k = 0; k < n; k++) send_beat(in_slice(k, base), k == 0, close_last && (k == n-1), SHW'(s));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d slices pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    int e0;
    for (int i = 0; i < 8; i++) orig[i] = 32'h1000_0000 + i;
    for (int k = 0; k < KN; k++) i_ext_field[(KN-1-k)*32 +: 32] = 32'hF000_0000 + k;
    i_ext_field[(KN-1-3)*32 +: 32] = 32'hDEAD_BEEF;

    tbl[0].rep = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; tbl[0].ms = 4'd0;
    tbl[0].exp = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                   32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007};
    tbl[1].rep = '{4'hB, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; tbl[1].ms = 4'd1;
    tbl[1].exp = '{32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004,
                   32'h10000005, 32'h10000006, 32'h10000007, 32'h00000000};
    tbl[2].rep = '{4'hB, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; tbl[2].ms = 4'd0;
    tbl[2].exp = '{32'hDEADBEEF, 32'h10000001, 32'h10000002, 32'h10000003,
                   32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007};
    tbl[3].rep = '{4'h0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; tbl[3].ms = 4'd1;
    tbl[3].exp = '{32'hDEADBEEF, 32'h10000002, 32'h10000003, 32'h10000004,
                   32'h10000005, 32'h10000006, 32'h10000007, 32'h00000000};
    tbl[4].rep = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0}; tbl[4].ms = 4'd2;
    tbl[4].exp = '{32'h10000002, 32'hF0000000, 32'h10000004, 32'hF0000000,
                   32'h10000006, 32'h10000007, 32'h00000000, 32'h00000000};
    tbl[5].rep = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h6, 4'hD}; tbl[5].ms = 4'd0;
    tbl[5].exp = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                   32'h10000004, 32'h10000005, 32'h10000006, 32'hF0000005};
    tbl[6].rep = '{4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; tbl[6].ms = 4'd8;
    tbl[6].exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[7].rep = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}; tbl[7].ms = 4'd15;
    tbl[7].exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[8].rep = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0}; tbl[8].ms = 4'd0;
    tbl[8].exp = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                   32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007};

    // Clock/reset
    rst_n = 1'b0;
    i_head_valid = 1'b0; i_head_data = '0; i_head_start = 1'b0; i_head_last = 1'b0;
    i_head_shift = '0; i_meta = pack_meta(orig); i_meta_shift = '0; i_replace = '0;
    i_head_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {o_head_valid, o_head_start, o_head_last, o_err, o_dbg_state}, 6'b0);
    chk("reset_data", o_head_data, '0);
    chk("reset_meta", o_meta, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Shift 4 over three slices, with first-output latency checks
    for (int k = 0; k < 3; k++) exp_q.push_back({k == 0, k == 2, exp_slice(3, 4, k, 8'h00)});
    send_beat(in_slice(0, 8'h00), 1'b1, 1'b0, 6'd4);
    chk("no_early_out", {{HW+1{1'b0}}, o_head_valid}, '0);
    send_beat(in_slice(1, 8'h00), 1'b0, 1'b0, 6'd4);
    chk("first_latency", {{HW{1'b0}}, o_head_valid, o_head_start}, 2'b11);
    send_beat(in_slice(2, 8'h00), 1'b0, 1'b1, 6'd4);
    wait_drain();

    // Single slice, shift 0, no replacement
    exp_q.push_back({2'b11, in_slice(0, 8'h40)});
    send_beat(in_slice(0, 8'h40), 1'b1, 1'b1, 6'd0);
    chk("single_latency", {{HW-1{1'b0}}, o_head_valid, o_head_start, o_head_last}, 3'b111);
    chk("single_meta", o_meta, pack_meta(orig));
    wait_drain();

    // Meta rewrite table
    for (int r = 0; r < 9; r++) begin
      i_replace    = pack_rep(tbl[r].rep);
      i_meta_shift = tbl[r].ms;
      exp_q.push_back({2'b11, in_slice(0, 8'(8'h20 + r))});
      send_beat(in_slice(0, 8'(8'h20 + r)), 1'b1, 1'b1, 6'd0);
      chk($sformatf("meta_r%0d", r), o_meta, pack_meta(tbl[r].exp));
      wait_drain();
    end
    i_replace = '0;
    i_meta_shift = '0;

    // Backpressure: ready toggles during a four-slice packet
    bp_mode = 1'b1;
    send_pkt(4, 3, 8'h80, 1'b1);
    wait_drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Start beat mid-packet closes the old packet, then the new one goes through
    e0 = err_seen;
    send_pkt(2, 2, 8'h10, 1'b0);
    exp_q.push_back({2'b11, in_slice(0, 8'h90)});
    send_beat(in_slice(0, 8'h90), 1'b1, 1'b1, 6'd0);
    wait_drain();
    chk("err_midstart", 32'(err_seen - e0), 32'd1);

    // Non-start beat while idle is dropped
    e0 = err_seen;
    send_beat(in_slice(0, 8'h55), 1'b0, 1'b0, 6'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_idle_drop", 32'(err_seen - e0), 32'd1);

    // Asynchronous reset mid-packet
    send_beat(in_slice(0, 8'h60), 1'b1, 1'b0, 6'd1);
    send_beat(in_slice(1, 8'h60), 1'b0, 1'b0, 6'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_mid_ctrl", {o_head_valid, o_head_start, o_head_last, o_err, o_dbg_state}, 6'b0);
    chk("rst_mid_data", o_head_data, '0);
    chk("rst_mid_meta", o_meta, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(2, 5, 8'hA0, 1'b1);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
